// File: rtl/alu_pkg.sv
// Shared ALU/multiplier definitions: adder opcodes, multiplier FSM states, step count.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam int MULT_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/adder.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained group to group.
module adder
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  alu_op_i,
  input  logic        c0_i,
  output logic [31:0] r_o,
  output logic        c32_o
);

  // Returns the carries out of bits 0..3 of one 4-bit group.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic cin);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  logic        sub;
  logic        cin;
  logic [31:0] b_eff;
  logic [31:0] g;
  logic [31:0] p;

  assign sub   = (alu_op_i == ALU_SUB);
  assign b_eff = sub ? ~b_i : b_i;
  assign cin   = c0_i | sub;
  assign g     = a_i & b_eff;
  assign p     = a_i ^ b_eff;

  genvar k;
  for (k = 0; k < 8; k++) begin : g_blk
    logic       blk_cin;
    logic [3:0] cy;
    if (k == 0) begin : g_first
      assign blk_cin = cin;
    end else begin : g_chain
      assign blk_cin = g_blk[k-1].cy[3];
    end
    assign cy           = cla4(g[4*k +: 4], p[4*k +: 4], blk_cin);
    assign r_o[4*k +: 4] = p[4*k +: 4] ^ {cy[2:0], blk_cin};
  end

  assign c32_o = g_blk[7].cy[3];

endmodule

// File: rtl/mult_seq.sv
// Sequential 32x32 unsigned shift-add multiplier driving the shared CLA adder.
// Optional early exit on exhausted multiplier bits: define MULT_SEQ_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one add/shift step per cycle, cnt = steps done
// DONE  | product held, out_valid high until out_ready
module mult_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product
);

  mult_state_t state_q, state_d;
  logic [63:0] p_q, p_d;
  logic [31:0] mc_q, mc_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [31:0] add_b;
  logic [31:0] add_r;
  logic        add_c32;
  logic        last_step;

  assign add_b = p_q[0] ? mc_q : 32'd0;

  adder u_adder (
    .a_i      (p_q[63:32]),
    .b_i      (add_b),
    .alu_op_i (ALU_ADD),
    .c0_i     (1'b0),
    .r_o      (add_r),
    .c32_o    (add_c32)
  );

  assign last_step = (cnt_q == 6'(MULT_STEPS - 1));

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // Remaining multiplier bits sit in lo[31-cnt:0]; once zero, every further step is a plain shift.
  logic [31:0] pend_mask;
  logic        pend_zero;
  logic [5:0]  skip_sh;

  assign pend_mask = 32'hFFFF_FFFF >> cnt_q;
  assign pend_zero = ~|(p_q[31:0] & pend_mask);
  assign skip_sh   = 6'(MULT_STEPS) - cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    mc_d    = mc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mc_d    = mcand;
          p_d     = {32'd0, mplier};
          cnt_d   = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MULT_SEQ_EARLY_EXIT_EN
        if (pend_zero) begin
          p_d     = p_q >> skip_sh;
          cnt_d   = cnt_q + 6'd1;
          state_d = DONE;
        end else
`endif
        begin
          // 65-bit {c32, sum, lo} shifted right by one; c32 lands in P[63].
          p_d   = {add_c32, add_r, p_q[31:1]};
          cnt_d = cnt_q + 6'd1;
          if (last_step) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= 64'd0;
      mc_q    <= 32'd0;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      mc_q    <= mc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = p_q;

endmodule
